// File: rtl/simon_pkg.sv
// simon_pkg: shared types and defaults for the Simon sequence blocks.
// Holds the controller state encoding, the colour codes and the default
// buffer geometry used by the sequence buffer and the playback reader.
package simon_pkg;

  // Default buffer geometry: 2-bit colour symbols, 16-entry store.
  localparam int DEF_DATA_WIDTH = 2;
  localparam int DEF_DEPTH      = 16;

  // Colour codes as stored in the buffer and reported by the buttons.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_e;

  // Reader controller states. DONE is kept in the encoding for the game
  // wrapper; the reader itself returns straight to IDLE with its result pulse.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_FETCH = 3'd1,
    SHOW    = 3'd2,
    GAP     = 3'd3,
    C_FETCH = 3'd4,
    WAIT    = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Larger of two integers, used to size the shared timer.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_timer.sv
// simon_timer: loadable down-counter with a zero flag.
// One instance is shared by the SHOW, GAP and (optional) press-timeout phases.
// A load takes priority over a decrement; the count holds at zero.
module simon_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Count register: synchronous reset, load, or saturating decrement.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/simon_playback.sv
// simon_playback: reader side of the Simon sequence buffer.
// Walks the stored sequence from index 0, shows each symbol on the LEDs for
// ON_CYCLES with OFF_CYCLES blank between symbols, then checks the player's
// presses against the same sequence and pulses PASS or FAIL for one cycle.
// Optional feature macro: SIMON_PLAYBACK_TIMEOUT_EN -- bounds each wait for a
// press to TIMEOUT_CYCLES; when undefined, the wait is unbounded.
module simon_playback
  import simon_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ON_CYCLES      = 8,
  parameter int OFF_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [LW-1:0]         LEN,
  output logic [AW-1:0]         RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  LED_VALID,
  output logic [DATA_WIDTH-1:0] LED_DATA,
  input  logic                  BTN_VALID,
  input  logic [DATA_WIDTH-1:0] BTN_DATA,
  output logic                  BUSY,
  output logic                  CHECKING,
  output logic                  PASS,
  output logic                  FAIL
);

  // The timer is sized for the longest phase it may ever hold, so its width
  // is identical whether or not the press timeout is built in.
  localparam int TW = $clog2(max_of(max_of(ON_CYCLES, OFF_CYCLES), TIMEOUT_CYCLES) + 1);

  // Phases end on the cycle the timer reads zero, so each load is N-1.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
`ifdef SIMON_PLAYBACK_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);

  // Plain state constants taken from the shared encoding.
  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_P_FETCH = P_FETCH;
  localparam logic [2:0] S_SHOW    = SHOW;
  localparam logic [2:0] S_GAP     = GAP;
  localparam logic [2:0] S_C_FETCH = C_FETCH;
  localparam logic [2:0] S_WAIT    = WAIT;
  localparam logic [2:0] S_DONE    = DONE;

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [LW-1:0] len_q;
  logic          pass_q;
  logic          fail_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_dec;
  logic          tmr_zero;

  logic [LW-1:0] len_sat;
  logic [AW-1:0] last_idx;
  logic          at_last;

  // A request longer than the store is clamped to the full store.
  assign len_sat = (LEN > DEPTH_LEN) ? DEPTH_LEN : LEN;

  // len_q is 1..DEPTH while busy, so len_q-1 always fits the address width
  // and the walk stops at DEPTH-1 without wrapping.
  assign last_idx = AW'(len_q - LW'(1));
  assign at_last  = (idx == last_idx);

  simon_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  // Timer control: reload on entry to each timed phase, count down inside it.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_dec   = 1'b0;
    case (state)
      S_P_FETCH: begin
        tmr_load  = 1'b1;
        tmr_value = ON_LOAD;
      end
      S_SHOW: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_GAP: begin
        tmr_dec = 1'b1;
      end
      S_C_FETCH: begin
`ifdef SIMON_PLAYBACK_TIMEOUT_EN
        tmr_load  = 1'b1;
        tmr_value = TO_LOAD;
`endif
      end
      S_WAIT: begin
`ifdef SIMON_PLAYBACK_TIMEOUT_EN
        tmr_dec = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

  // Main controller: sequence walk, press checking and registered result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      idx    <= '0;
      len_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // An empty sequence has nothing to play, so the request is dropped.
          if (START && (LEN != '0)) begin
            len_q <= len_sat;
            idx   <= '0;
            state <= S_P_FETCH;
          end
        end
        S_P_FETCH: begin
          // One cycle for the buffer read data to follow the new address.
          state <= S_SHOW;
        end
        S_SHOW: begin
          if (tmr_zero) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_zero) begin
            if (at_last) begin
              idx   <= '0;
              state <= S_C_FETCH;
            end else begin
              idx   <= idx + AW'(1);
              state <= S_P_FETCH;
            end
          end
        end
        S_C_FETCH: begin
          // Presses here are dropped: the expected symbol is not yet valid.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (BTN_VALID) begin
            if (BTN_DATA != RD_DATA) begin
              fail_q <= 1'b1;
              idx    <= '0;
              state  <= S_IDLE;
            end else if (at_last) begin
              pass_q <= 1'b1;
              idx    <= '0;
              state  <= S_IDLE;
            end else begin
              idx   <= idx + AW'(1);
              state <= S_C_FETCH;
            end
          end
`ifdef SIMON_PLAYBACK_TIMEOUT_EN
          else if (tmr_zero) begin
            fail_q <= 1'b1;
            idx    <= '0;
            state  <= S_IDLE;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: LEDs mirror the read data only while a symbol is shown.
  assign RD_ADDR   = idx;
  assign LED_VALID = (state == S_SHOW);
  assign LED_DATA  = LED_VALID ? RD_DATA : '0;
  assign BUSY      = (state != S_IDLE);
  assign CHECKING  = (state == S_WAIT);
  assign PASS      = pass_q;
  assign FAIL      = fail_q;

endmodule

// File: tb/tb_simon_playback.sv
// tb_simon_playback: directed self-checking bench for simon_playback.
// A small registered memory stands in for the sequence buffer (read data one
// cycle after the address). Expected LED timing is derived from the symbol
// period 1 + ON + OFF = 13 cycles. Optional macro: SIMON_PLAYBACK_TIMEOUT_EN.
module tb_simon_playback;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] len;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic       led_valid;
  logic [1:0] led_data;
  logic       btn_valid;
  logic [1:0] btn_data;
  logic       busy;
  logic       checking;
  logic       pass;
  logic       fail;

  logic [1:0] mem [16];

  int total = 0;
  int bad   = 0;

  simon_playback dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .LEN       (len),
    .RD_ADDR   (rd_addr),
    .RD_DATA   (rd_data),
    .LED_VALID (led_valid),
    .LED_DATA  (led_data),
    .BTN_VALID (btn_valid),
    .BTN_DATA  (btn_data),
    .BUSY      (busy),
    .CHECKING  (checking),
    .PASS      (pass),
    .FAIL      (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequence buffer model: registered read, valid one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {pass, fail, busy, checking, led_valid, led_data, rd_addr};
  endfunction

  task automatic go(input int l);
    start = 1'b1;
    len   = 5'(l);
    tick();
    start = 1'b0;
  endtask

  // Checks the whole playback, cycle by cycle, from the first cycle after the
  // accepted START through C_FETCH, then the first CHECKING cycle. With noise
  // set, START and wrong-colour presses are injected every fifth cycle.
  task automatic playback(input int n, input bit noise);
    for (int c = 1; c <= 13 * n + 1; c++) begin
      int         sym;
      int         ph;
      logic       ev;
      logic [1:0] ed;
      logic [3:0] ea;
      sym = (c - 1) / 13;
      ph  = (c - 1) % 13;
      ev  = (c <= 13 * n) && (ph >= 1) && (ph <= 8);
      ed  = ev ? mem[sym] : 2'd0;
      ea  = (c <= 13 * n) ? 4'(sym) : 4'd0;
      check($sformatf("play c=%0d", c), {busy, checking, led_valid, led_data, rd_addr},
            {1'b1, 1'b0, ev, ed, ea});
      if (noise) begin
        start     = ((c % 5) == 0);
        len       = 5'd1;
        btn_valid = ((c % 5) == 0);
        btn_data  = ~mem[0];
      end
      tick();
    end
    start     = 1'b0;
    btn_valid = 1'b0;
    check($sformatf("checking_rise n=%0d", n), {busy, checking, led_valid}, 3'b110);
  endtask

  // Presses the stored sequence correctly, starting in WAIT.
  task automatic answer(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("wait i=%0d", i), {busy, checking}, 2'b11);
      btn_valid = 1'b1;
      btn_data  = mem[i];
      tick();
      btn_valid = 1'b0;
      if (i < n - 1) begin
        check($sformatf("cfetch i=%0d", i), {busy, checking, rd_addr}, {1'b1, 1'b0, 4'(i + 1)});
        tick();
      end else begin
        check($sformatf("pass n=%0d", n), {pass, fail, busy}, 3'b100);
        tick();
        check($sformatf("pass_once n=%0d", n), {pass, fail, busy}, 3'b000);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 5'd0;
    btn_valid = 1'b0;
    btn_data  = 2'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    tick();
    tick();
    check("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_outs", 32'(outs()), 32'd0);

    // Three symbols {1,3,0}, answered correctly.
    mem[0] = 2'd1;
    mem[1] = 2'd3;
    mem[2] = 2'd0;
    go(3);
    playback(3, 1'b0);
    answer(3);

    // Same buffer, second press wrong.
    go(3);
    playback(3, 1'b0);
    btn_valid = 1'b1;
    btn_data  = 2'd1;
    tick();
    btn_valid = 1'b0;
    check("wrong_cfetch", {busy, checking}, 2'b10);
    tick();
    check("wrong_wait", {busy, checking}, 2'b11);
    btn_valid = 1'b1;
    btn_data  = 2'd2;
    tick();
    btn_valid = 1'b0;
    check("wrong_result", {pass, fail, busy, led_valid, led_data}, 6'b010000);
    tick();
    check("wrong_once", {pass, fail, busy}, 3'b000);

    // Full store of alternating 2,1.
    for (int i = 0; i < 16; i++) mem[i] = ((i % 2) == 0) ? 2'd2 : 2'd1;
    go(16);
    playback(16, 1'b0);
    answer(16);

    // START with LEN=0 is ignored.
    start = 1'b1;
    len   = 5'd0;
    tick();
    start = 1'b0;
    check("len0_busy_a", {busy, pass, fail}, 3'b000);
    tick();
    check("len0_busy_b", {busy, pass, fail}, 3'b000);

    // START and wrong presses during playback are ignored.
    mem[0] = 2'd1;
    mem[1] = 2'd3;
    mem[2] = 2'd0;
    go(3);
    playback(3, 1'b1);
    answer(3);

    // Reset in the second symbol's GAP aborts with no result pulse.
    go(3);
    for (int k = 0; k < 22; k++) tick();
    check("pre_reset_gap", {busy, led_valid, rd_addr}, {1'b1, 1'b0, 4'd1});
    rst = 1'b1;
    tick();
    check("mid_reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_reset k=%0d", k), {pass, fail, busy}, 3'b000);
    end

    // Long wait in WAIT: timeout when built in, otherwise unbounded.
    mem[0] = 2'd0;
    mem[1] = 2'd3;
    go(2);
    playback(2, 1'b0);
`ifdef SIMON_PLAYBACK_TIMEOUT_EN
    for (int k = 0; k < 63; k++) tick();
    check("timeout_last_wait", {fail, busy, checking}, 3'b011);
    tick();
    check("timeout_fail", {pass, fail, busy}, 3'b010);
    tick();
    check("timeout_once", {pass, fail, busy}, 3'b000);
`else
    for (int k = 0; k < 200; k++) tick();
    check("long_wait", {pass, fail, busy, checking}, 4'b0011);
    answer(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
